esl_cut_counter: RTL and testbench

// - Responder end of the clock-check counting handshake: counts clock-under-test (cut_clk) cycles.
// - Driven by the ref_clk-domain control FSM through reset_cut_count/en_cut_count.
// - Returns reset_ack, cut_count_available and the frozen count in the ref_clk domain.
// - Owns all CDC between ref_clk and cut_clk for the clock checker.

---
 rtl/esl_clk_check_pkg.sv | 24 ++
 rtl/esl_bit_sync.sv | 40 ++++
 rtl/esl_cut_counter.sv | 230 +++++++++++++++++++++++
 tb/tb_esl_cut_counter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/esl_clk_check_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : esl_clk_check_pkg
// Brief    : Shared types and default sizes for the clock-checker cut counter.
// Revision : 1.0 - initial release
// ============================================================================
package esl_clk_check_pkg;

    // Default width of the cut_clk cycle counter
    localparam int c_cnt_w_def       = 16;
    // Default flop count per synchronizer chain (must be >= 2)
    localparam int c_sync_stages_def = 2;

    // Cut-domain handshake state
    typedef enum logic [1:0] {
        CUT_IDLE     = 2'd0,
        CUT_CLEARING = 2'd1,
        CUT_COUNTING = 2'd2,
        CUT_HOLD     = 2'd3
    } cut_state_e;

endpackage : esl_clk_check_pkg
`default_nettype wire

// File: rtl/esl_bit_sync.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : esl_bit_sync
// Brief    : Single-bit multi-flop synchronizer with asynchronous active-low
//            reset. Output is the last flop of a STAGES-deep shift chain.
// Revision : 1.0 - initial release
// ============================================================================
module esl_bit_sync
    import esl_clk_check_pkg::*;
#(
    parameter int STAGES = c_sync_stages_def
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    // Shift the asynchronous input one flop further down the chain
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], i_d};
    end

    // Synchronizer chain registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign o_q = sync_q[STAGES-1];

endmodule : esl_bit_sync
`default_nettype wire

// File: rtl/esl_cut_counter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : esl_cut_counter
// Brief    : Responder side of the clock-check counting handshake. Counts
//            cut_clk cycles while enabled, and reports clear acknowledge,
//            availability and the frozen count back in the ref_clk domain.
//            Holds every ref_clk <-> cut_clk crossing of the clock checker.
//            Build option ESL_CUT_COUNT_SATURATE_EN: counter saturates and
//            flags overflow instead of wrapping.
// Revision : 1.0 - initial release
// ============================================================================
module esl_cut_counter
    import esl_clk_check_pkg::*;
#(
    parameter int CNT_W       = c_cnt_w_def,
    parameter int SYNC_STAGES = c_sync_stages_def
) (
    input  logic             ref_clk,
    input  logic             ref_rst_n,
    input  logic             cut_clk,
    input  logic             reset_cut_count,
    input  logic             en_cut_count,
    output logic             reset_ack,
    output logic             cut_count_available,
    output logic [CNT_W-1:0] cut_count,
    output logic             cut_count_overflow
);

    // ------------------------------------------------------------------
    // Cut-domain reset: asserted with ref_rst_n, released on cut_clk
    // ------------------------------------------------------------------
    logic w_cut_rst_n;

    esl_bit_sync #(.STAGES(SYNC_STAGES)) u_cut_rst_sync (
        .clk   (cut_clk),
        .rst_n (ref_rst_n),
        .i_d   (1'b1),
        .o_q   (w_cut_rst_n)
    );

    // ------------------------------------------------------------------
    // ref -> cut request synchronizers
    // ------------------------------------------------------------------
    logic w_rst_s;
    logic w_en_s;

    esl_bit_sync #(.STAGES(SYNC_STAGES)) u_rst_sync (
        .clk   (cut_clk),
        .rst_n (w_cut_rst_n),
        .i_d   (reset_cut_count),
        .o_q   (w_rst_s)
    );

    esl_bit_sync #(.STAGES(SYNC_STAGES)) u_en_sync (
        .clk   (cut_clk),
        .rst_n (w_cut_rst_n),
        .i_d   (en_cut_count),
        .o_q   (w_en_s)
    );

    // ------------------------------------------------------------------
    // Cut-domain FSM and counter
    // ------------------------------------------------------------------
    cut_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             ovf_q,   ovf_d;
    logic             ack_q,   ack_d;
    logic             done_q,  done_d;

`ifdef ESL_CUT_COUNT_SATURATE_EN
    localparam logic [CNT_W-1:0] c_cnt_max = '1;
`endif

    // Next state first, then register updates keyed on the state being
    // entered so ack/done leave one cut cycle after the request is seen
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        ack_d   = ack_q;
        done_d  = done_q;

        case (state_q)
            CUT_IDLE: begin
                if (w_rst_s) begin
                    state_d = CUT_CLEARING;
                end else if (w_en_s) begin
                    state_d = CUT_COUNTING;
                end
            end
            CUT_CLEARING: begin
                if (!w_rst_s) begin
                    state_d = w_en_s ? CUT_COUNTING : CUT_IDLE;
                end
            end
            CUT_COUNTING: begin
                if (w_rst_s) begin
                    state_d = CUT_CLEARING;
                end else if (!w_en_s) begin
                    state_d = CUT_HOLD;
                end
            end
            CUT_HOLD: begin
                // Enable is ignored here; only a clear restarts the cycle
                if (w_rst_s) begin
                    state_d = CUT_CLEARING;
                end
            end
            default: begin
                state_d = CUT_IDLE;
            end
        endcase

        case (state_d)
            CUT_CLEARING: begin
                cnt_d  = '0;
                ovf_d  = 1'b0;
                ack_d  = 1'b1;
                done_d = 1'b0;
            end
            CUT_COUNTING: begin
                ack_d = 1'b0;
`ifdef ESL_CUT_COUNT_SATURATE_EN
                if (cnt_q == c_cnt_max) begin
                    ovf_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`else
                cnt_d = cnt_q + CNT_W'(1);
`endif
            end
            CUT_HOLD: begin
                done_d = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Cut-domain state, counter and handshake flags
    always_ff @(posedge cut_clk or negedge w_cut_rst_n) begin
        if (!w_cut_rst_n) begin
            state_q <= CUT_IDLE;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            ack_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            ack_q   <= ack_d;
            done_q  <= done_d;
        end
    end

    // ------------------------------------------------------------------
    // cut -> ref flag synchronizers
    // ------------------------------------------------------------------
    logic w_ack_s;
    logic w_done_s;

    esl_bit_sync #(.STAGES(SYNC_STAGES)) u_ack_sync (
        .clk   (ref_clk),
        .rst_n (ref_rst_n),
        .i_d   (ack_q),
        .o_q   (w_ack_s)
    );

    esl_bit_sync #(.STAGES(SYNC_STAGES)) u_done_sync (
        .clk   (ref_clk),
        .rst_n (ref_rst_n),
        .i_d   (done_q),
        .o_q   (w_done_s)
    );

    // ------------------------------------------------------------------
    // Ref-domain outputs and capture
    // ------------------------------------------------------------------
    logic             reset_ack_q,   reset_ack_d;
    logic             done_dly_q,    done_dly_d;
    logic             avail_q,       avail_d;
    logic [CNT_W-1:0] count_cap_q,   count_cap_d;
    logic             ovf_cap_q,     ovf_cap_d;

    // cnt_q/ovf_q are read across domains only on the done rising edge,
    // when the cut side has held them frozen for the whole sync latency
    always_comb begin
        reset_ack_d = w_ack_s & reset_cut_count;
        done_dly_d  = w_done_s;
        avail_d     = avail_q;
        count_cap_d = count_cap_q;
        ovf_cap_d   = ovf_cap_q;

        if (reset_cut_count) begin
            avail_d = 1'b0;
        end else if (w_done_s && !done_dly_q) begin
            count_cap_d = cnt_q;
            ovf_cap_d   = ovf_q;
            avail_d     = 1'b1;
        end
    end

    // Ref-domain output registers
    always_ff @(posedge ref_clk or negedge ref_rst_n) begin
        if (!ref_rst_n) begin
            reset_ack_q <= 1'b0;
            done_dly_q  <= 1'b0;
            avail_q     <= 1'b0;
            count_cap_q <= '0;
            ovf_cap_q   <= 1'b0;
        end else begin
            reset_ack_q <= reset_ack_d;
            done_dly_q  <= done_dly_d;
            avail_q     <= avail_d;
            count_cap_q <= count_cap_d;
            ovf_cap_q   <= ovf_cap_d;
        end
    end

    assign reset_ack           = reset_ack_q;
    assign cut_count_available = avail_q;
    assign cut_count           = count_cap_q;
    // In the wrapping build ovf_q is never set, so this is constant 0
    assign cut_count_overflow  = ovf_cap_q;

endmodule : esl_cut_counter
`default_nettype wire

// File: tb/tb_esl_cut_counter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_esl_cut_counter
// Brief    : Directed self-checking bench for esl_cut_counter. A 16-bit
//            instance runs from a gateable 50 MHz cut clock, an 8-bit
//            instance from a free-running 400 MHz cut clock; ref is 100 MHz.
// Revision : 1.0 - initial release
// ============================================================================
module tb_esl_cut_counter;

    logic ref_clk   = 1'b0;
    logic ref_rst_n = 1'b0;
    logic cut_free  = 1'b0;
    logic cut_run   = 1'b0;
    logic cut8_clk  = 1'b0;
    logic cut_clk;

    always #5    ref_clk  = ~ref_clk;
    always #10   cut_free = ~cut_free;
    always #1.25 cut8_clk = ~cut8_clk;
    assign cut_clk = cut_free & cut_run;

    // 16-bit instance
    logic        reset_cut_count = 1'b0;
    logic        en_cut_count    = 1'b0;
    logic        reset_ack;
    logic        cut_count_available;
    logic [15:0] cut_count;
    logic        cut_count_overflow;

    // 8-bit instance
    logic       r8 = 1'b0;
    logic       e8 = 1'b0;
    logic       ack8;
    logic       avail8;
    logic [7:0] cnt8;
    logic       ovf8;

    esl_cut_counter #(.CNT_W(16), .SYNC_STAGES(2)) dut (
        .ref_clk             (ref_clk),
        .ref_rst_n           (ref_rst_n),
        .cut_clk             (cut_clk),
        .reset_cut_count     (reset_cut_count),
        .en_cut_count        (en_cut_count),
        .reset_ack           (reset_ack),
        .cut_count_available (cut_count_available),
        .cut_count           (cut_count),
        .cut_count_overflow  (cut_count_overflow)
    );

    esl_cut_counter #(.CNT_W(8), .SYNC_STAGES(2)) dut8 (
        .ref_clk             (ref_clk),
        .ref_rst_n           (ref_rst_n),
        .cut_clk             (cut8_clk),
        .reset_cut_count     (r8),
        .en_cut_count        (e8),
        .reset_ack           (ack8),
        .cut_count_available (avail8),
        .cut_count           (cnt8),
        .cut_count_overflow  (ovf8)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Advance n ref cycles and land 1 ns after the edge
    task automatic tick(input int n);
        repeat (n) @(posedge ref_clk);
        #1;
    endtask

    // Full clear / count-1000-ref-cycles / capture sequence on the 16-bit DUT
    task automatic main_cycle(input string tag);
        bit seen;
        int waited;
        seen = 1'b0;
        reset_cut_count = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (reset_ack) seen = 1'b1;
        end
        check({tag, "_ack_pulse"}, 32'(seen), 1);
        check({tag, "_ack_high"}, 32'(reset_ack), 1);
        check({tag, "_avail_clr"}, 32'(cut_count_available), 0);
        reset_cut_count = 1'b0;
        tick(1);
        check({tag, "_ack_fall"}, 32'(reset_ack), 0);
        en_cut_count = 1'b1;
        tick(1000);
        en_cut_count = 1'b0;
        waited = 0;
        while (!cut_count_available && waited < 50) begin
            tick(1);
            waited++;
        end
        check({tag, "_avail"}, 32'(cut_count_available), 1);
        check({tag, "_count_500pm1"}, 32'(cut_count >= 16'd499 && cut_count <= 16'd501), 1);
        check({tag, "_ovf"}, 32'(cut_count_overflow), 0);
    endtask

    initial begin
        int  waited;
        bit  bad_ack;
        bit  bad_av;

        // ---------------- reset state ----------------
        #23;
        check("rst_ack",   32'(reset_ack), 0);
        check("rst_avail", 32'(cut_count_available), 0);
        check("rst_count", 32'(cut_count), 0);
        check("rst_ovf",   32'(cut_count_overflow), 0);
        check("rst_avail8", 32'(avail8), 0);
        tick(1);
        ref_rst_n = 1'b1;
        tick(2);

        // ---------------- stopped cut clock ----------------
        bad_ack = 1'b0;
        bad_av  = 1'b0;
        reset_cut_count = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            tick(1);
            if (reset_ack) bad_ack = 1'b1;
            if (cut_count_available) bad_av = 1'b1;
        end
        check("stop_ack_seen",   32'(bad_ack), 0);
        check("stop_avail_seen", 32'(bad_av), 0);
        reset_cut_count = 1'b0;
        tick(2);

        // Start the cut clock glitch-free
        @(negedge cut_free);
        cut_run = 1'b1;
        tick(5);

        // ---------------- 8-bit counter, cut = 4x ref ----------------
        r8 = 1'b1;
        tick(20);
        check("w8_ack", 32'(ack8), 1);
        r8 = 1'b0;
        tick(1);
        e8 = 1'b1;
        tick(100);
        e8 = 1'b0;
        waited = 0;
        while (!avail8 && waited < 50) begin
            tick(1);
            waited++;
        end
        check("w8_avail", 32'(avail8), 1);
`ifdef ESL_CUT_COUNT_SATURATE_EN
        check("w8_count_sat", 32'(cnt8), 255);
        check("w8_ovf", 32'(ovf8), 1);
`else
        check("w8_count_wrap", 32'(cnt8 >= 8'd143 && cnt8 <= 8'd145), 1);
        check("w8_ovf", 32'(ovf8), 0);
`endif

        // ---------------- basic count cycle ----------------
        main_cycle("t1");

        // ---------------- clear after available ----------------
        reset_cut_count = 1'b1;
        tick(1);
        check("clr_avail_next", 32'(cut_count_available), 0);
        check("clr_count_hold", 32'(cut_count >= 16'd499 && cut_count <= 16'd501), 1);
        waited = 0;
        while (!reset_ack && waited < 30) begin
            tick(1);
            waited++;
        end
        check("clr_ack", 32'(reset_ack), 1);
        reset_cut_count = 1'b0;
        tick(5);

        // ---------------- simultaneous clear and enable ----------------
        reset_cut_count = 1'b1;
        en_cut_count    = 1'b1;
        tick(200);
        check("both_ack", 32'(reset_ack), 1);
        check("both_avail", 32'(cut_count_available), 0);
        en_cut_count = 1'b0;
        tick(10);
        reset_cut_count = 1'b0;
        tick(20);
        check("both_no_capture", 32'(cut_count_available), 0);
        // Short window: a count near 10 proves the counter restarted from 0
        en_cut_count = 1'b1;
        tick(20);
        en_cut_count = 1'b0;
        waited = 0;
        while (!cut_count_available && waited < 50) begin
            tick(1);
            waited++;
        end
        check("both_avail_after", 32'(cut_count_available), 1);
        check("both_count_10pm1", 32'(cut_count >= 16'd9 && cut_count <= 16'd11), 1);

        // ---------------- async reset mid-count ----------------
        reset_cut_count = 1'b1;
        tick(20);
        reset_cut_count = 1'b0;
        tick(1);
        en_cut_count = 1'b1;
        tick(600);
        #3;
        ref_rst_n = 1'b0;
        #1;
        check("arst_ack",   32'(reset_ack), 0);
        check("arst_avail", 32'(cut_count_available), 0);
        check("arst_count", 32'(cut_count), 0);
        check("arst_ovf",   32'(cut_count_overflow), 0);
        check("arst_count8", 32'(cnt8), 0);
        en_cut_count = 1'b0;
        tick(5);
        ref_rst_n = 1'b1;
        tick(10);
        check("arst_rel_ack",   32'(reset_ack), 0);
        check("arst_rel_avail", 32'(cut_count_available), 0);
        main_cycle("t5");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Absolute watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $finish;
    end

endmodule : tb_esl_cut_counter
`default_nettype wire
